video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Raster timing generator and pixel-fetch aligner sitting directly upstream of the HDMI output stage.
//  Runs H/V counters, requests pixels from a fixed-latency pixel source by (x,y), then re-aligns the returned RGB
//  with registered hs/vs/de so the HDMI encoder inputs (r,g,b,hs,vs,de) arrive cycle-coherent.
// PARAMETERS
//  H_ACTIVE 640  active pixels/line;  H_FP 16  front porch;  H_SYNC 96  sync width;  H_BP 48  back porch
//  V_ACTIVE 480  active lines/frame;  V_FP 10  front porch;  V_SYNC 2  sync lines;  V_BP 33  back porch
//  HS_POL 0  hsync active level (0=active-low);  VS_POL 0  vsync active level
//  PIX_LAT 2  clk_pixel cycles from pix_req/pix_x/pix_y to valid pix_r/g/b (legal 1..8)
//  H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise; both must be <=4095
// PORTS
//  clk_pixel    in   1   pixel clock, all logic on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  enable       in   1   1=run raster; 0=hold counters at (0,0), emit blanking
//  pix_req      out  1   pixel request, high exactly when stage-0 position is active
//  pix_x        out  12  requested column (0 when pix_req=0)
//  pix_y        out  12  requested line (0 when pix_req=0)
//  pix_r/g/b    in   8   pixel data, valid PIX_LAT cycles after matching pix_req
//  r_out/g_out/b_out out 8  aligned pixel to HDMI stage, forced 0 when de_out=0
//  hs_out/vs_out out 1   aligned syncs at configured polarity
//  de_out       out  1   aligned data enable
//  line_start   out  1   1-cycle pulse coincident with first de_out of every active line
//  frame_start  out  1   1-cycle pulse coincident with first de_out of line 0
// BEHAVIOUR
//  Reset (async, rst_n=0): h_cnt=v_cnt=0, delay pipes cleared; r/g/b_out=0, de_out=0, line_start=frame_start=0,
//   hs_out=~HS_POL, vs_out=~VS_POL; pix_req=0, pix_x=pix_y=0. Release sync is the integrator's job.
//  Counters: h_cnt 0..H_TOTAL-1 wraps to 0 and increments v_cnt; v_cnt 0..V_TOTAL-1 wraps to 0 at h wrap.
//   enable=0: both counters synchronously cleared to 0 each edge (enable drop mid-line aborts the frame).
//  Stage 0 (combinational from counters, qualified by enable):
//   act0 = enable & h_cnt<H_ACTIVE & v_cnt<V_ACTIVE; pix_req=act0; pix_x/pix_y = act0 ? h_cnt/v_cnt : 0.
//   hs0 = enable & H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
//   vs0 = enable & V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (whole lines, edge aligned to h_cnt=0).
//  Alignment: act0/hs0/vs0 shifted through a PIX_LAT-deep register pipe; at PIX_LAT depth they are registered
//   together with pix_r/g/b into the output stage. Total latency stage0 -> outputs = PIX_LAT+1 edges, fixed.
//  Output stage: de_out=act_d; rgb = act_d ? pix : 0; hs_out=hs_d^~HS_POL; vs_out=vs_d^~VS_POL.
//   line_start = act_d & ~de_out(prev); frame_start = line_start & (line index 0, carried as a pipe bit).
//  enable deassert: in-flight pipe contents drain normally; blanking reaches outputs PIX_LAT+1 edges later.
//  enable reassert: first enabled cycle is stage-0 (0,0); de_out/frame_start rise PIX_LAT+1 edges later.
//  No back-pressure: pix source must honour PIX_LAT exactly; pix data outside act_d is ignored.
// TESTING
//  1. Reset, enable=1 at edge E: pix_req=1 with (0,0) before E; de_out=1, frame_start=1 after edge E+PIX_LAT (default E+2).
//  2. Default params, one full frame: exactly 420000 cycles between frame_start pulses; de_out high 640x480=307200 cycles;
//     hs_out=0 for 96 cycles from h_cnt=656 every line; vs_out=0 for lines 490-491 (1600 cycles).
//  3. Pixel model returns {x[7:0], y[7:0], x[7:0]^y[7:0]} after PIX_LAT: every de_out cycle r/g/b match the expected (x,y)
//     sequence; rgb=0 whenever de_out=0, even if model drives 8'hFF.
//  4. enable dropped at (h=300,v=100) for 5 cycles: de_out low from PIX_LAT+1 edges later; on re-enable next
//     frame_start at correct latency, pix_x/pix_y restart at 0,0.
//  5. rst_n pulsed low mid-active-line: outputs hit reset values without a clock edge; after release raster restarts at (0,0).
//  6. Small config H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1,HS_POL=1,PIX_LAT=1:
//     8-cycle lines, 6-line frame; hs_out high 2 cycles/line, line_start 3 per frame, wrap at h=7/v=5 correct.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// Pixel-fetch request/return bus and the aligned HDMI-encoder output bundle.
// The master side is the timing generator; the slave side is the pixel source plus the HDMI stage.
interface video_timing_gen_if;
  logic        pix_req;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic [7:0]  pix_r;
  logic [7:0]  pix_g;
  logic [7:0]  pix_b;
  logic [7:0]  r_out;
  logic [7:0]  g_out;
  logic [7:0]  b_out;
  logic        hs_out;
  logic        vs_out;
  logic        de_out;
  logic        line_start;
  logic        frame_start;

  modport master (
    output pix_req, pix_x, pix_y,
    output r_out, g_out, b_out, hs_out, vs_out, de_out, line_start, frame_start,
    input  pix_r, pix_g, pix_b
  );

  modport slave (
    input  pix_req, pix_x, pix_y,
    input  r_out, g_out, b_out, hs_out, vs_out, de_out, line_start, frame_start,
    output pix_r, pix_g, pix_b
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V counters drive pixel requests, and the fixed-latency pixel return is
// re-aligned with delayed hs/vs/de so the HDMI encoder sees one cycle-coherent word per pixel.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_LAT  = 2
) (
  input  logic               clk_pixel,
  input  logic               rst_n,
  input  logic               enable,
  video_timing_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LAST    = PIX_LAT - 1;

  localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS_C   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE_C   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST_C = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS_C   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE_C   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST_C = 12'(V_TOTAL - 1);

  function automatic logic [7:0] blank_px(input logic vld, input logic [7:0] px);
    return vld ? px : 8'd0;
  endfunction

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST_C) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST_C) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Stage 0: decode from counters; reset also masks the request so pix_req reads 0 while held
  logic run_p0;
  logic vld_p0;
  logic hs_p0;
  logic vs_p0;
  logic first_p0;

  assign run_p0   = enable & rst_n;
  assign vld_p0   = run_p0 & (h_cnt < H_ACT_C) & (v_cnt < V_ACT_C);
  assign hs_p0    = run_p0 & (h_cnt >= H_SS_C) & (h_cnt < H_SE_C);
  assign vs_p0    = run_p0 & (v_cnt >= V_SS_C) & (v_cnt < V_SE_C);
  assign first_p0 = (v_cnt == 12'd0);

  assign vif.pix_req = vld_p0;
  assign vif.pix_x   = vld_p0 ? h_cnt : 12'd0;
  assign vif.pix_y   = vld_p0 ? v_cnt : 12'd0;

  // Stage 1: PIX_LAT-deep delay matching the pixel source latency
  logic [PIX_LAT-1:0] vld_p1;
  logic [PIX_LAT-1:0] hs_p1;
  logic [PIX_LAT-1:0] vs_p1;
  logic [PIX_LAT-1:0] first_p1;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= '0;
      hs_p1    <= '0;
      vs_p1    <= '0;
      first_p1 <= '0;
    end else begin
      vld_p1[0]   <= vld_p0;
      hs_p1[0]    <= hs_p0;
      vs_p1[0]    <= vs_p0;
      first_p1[0] <= first_p0;
      for (int i = 1; i < PIX_LAT; i++) begin
        vld_p1[i]   <= vld_p1[i-1];
        hs_p1[i]    <= hs_p1[i-1];
        vs_p1[i]    <= vs_p1[i-1];
        first_p1[i] <= first_p1[i-1];
      end
    end
  end

  // Stage 2: output register, pixel data joins its delayed timing here
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      vif.de_out      <= 1'b0;
      vif.r_out       <= 8'd0;
      vif.g_out       <= 8'd0;
      vif.b_out       <= 8'd0;
      vif.hs_out      <= ~HS_POL;
      vif.vs_out      <= ~VS_POL;
      vif.line_start  <= 1'b0;
      vif.frame_start <= 1'b0;
    end else begin
      vif.de_out      <= vld_p1[LAST];
      vif.r_out       <= blank_px(vld_p1[LAST], vif.pix_r);
      vif.g_out       <= blank_px(vld_p1[LAST], vif.pix_g);
      vif.b_out       <= blank_px(vld_p1[LAST], vif.pix_b);
      vif.hs_out      <= hs_p1[LAST] ^ ~HS_POL;
      vif.vs_out      <= vs_p1[LAST] ^ ~VS_POL;
      vif.line_start  <= vld_p1[LAST] & ~vif.de_out;
      vif.frame_start <= vld_p1[LAST] & ~vif.de_out & first_p1[LAST];
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 640x480 instance and a tiny 8x6 instance, each checked every
// cycle against a raster model derived from an enabled-cycle count, plus directed latency/count checks.
module tb_video_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] en = 2'b00;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
  endtask

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic        first;
    logic [11:0] x;
    logic [11:0] y;
  } s0_t;

  for (genvar c = 0; c < 2; c++) begin : g_cfg
    localparam int HA  = (c == 0) ? 640 : 4;
    localparam int HF  = (c == 0) ? 16  : 1;
    localparam int HSY = (c == 0) ? 96  : 2;
    localparam int HB  = (c == 0) ? 48  : 1;
    localparam int VA  = (c == 0) ? 480 : 3;
    localparam int VF  = (c == 0) ? 10  : 1;
    localparam int VSY = (c == 0) ? 2   : 1;
    localparam int VB  = (c == 0) ? 33  : 1;
    localparam bit HP  = (c == 0) ? 1'b0 : 1'b1;
    localparam bit VP  = 1'b0;
    localparam int LAT = (c == 0) ? 2 : 1;
    localparam int HT  = HA + HF + HSY + HB;
    localparam int VT  = VA + VF + VSY + VB;

    video_timing_gen_if vif();

    video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .HS_POL(HP), .VS_POL(VP), .PIX_LAT(LAT)
    ) dut (
      .clk_pixel(clk),
      .rst_n    (rst_n),
      .enable   (en[c]),
      .vif      (vif)
    );

    // Raster position is simply the number of consecutive enabled edges, folded into (h, v).
    function automatic s0_t pos(input logic e, input int n);
      s0_t s;
      int  h;
      int  v;
      h = n % HT;
      v = (n / HT) % VT;
      s.act   = e && (h < HA) && (v < VA);
      s.hs    = e && (h >= HA + HF) && (h < HA + HF + HSY);
      s.vs    = e && (v >= VA + VF) && (v < VA + VF + VSY);
      s.first = s.act && (v == 0);
      s.x     = s.act ? 12'(h) : 12'd0;
      s.y     = s.act ? 12'(v) : 12'd0;
      return s;
    endfunction

    initial begin
      s0_t        hist[$];
      s0_t        src[$];
      s0_t        cur;
      s0_t        eo;
      s0_t        rq;
      int         cnt;
      logic       prev_de;
      logic       ls_e;
      logic [7:0] xr;
      logic [7:0] yr;
      cnt = 0;
      prev_de = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          hist.delete();
          for (int i = 0; i <= LAT; i++) hist.push_back('0);
          cnt = 0;
          prev_de = 1'b0;
          chk($sformatf("c%0d reset_hold", c),
              {vif.de_out, vif.line_start, vif.frame_start, vif.hs_out, vif.vs_out,
               vif.r_out, vif.g_out, vif.b_out, vif.pix_req, vif.pix_x, vif.pix_y},
              {3'b000, !HP, !VP, 24'd0, 1'b0, 24'd0});
        end else begin
          cur = pos(en[c], cnt);
          chk($sformatf("c%0d req", c), {vif.pix_req, vif.pix_x, vif.pix_y}, {cur.act, cur.x, cur.y});
          eo = hist[0];
          xr = eo.x[7:0];
          yr = eo.y[7:0];
          ls_e = eo.act & ~prev_de;
          chk($sformatf("c%0d de", c), vif.de_out, eo.act);
          chk($sformatf("c%0d hs", c), vif.hs_out, eo.hs ? HP : !HP);
          chk($sformatf("c%0d vs", c), vif.vs_out, eo.vs ? VP : !VP);
          chk($sformatf("c%0d rgb", c), {vif.r_out, vif.g_out, vif.b_out},
              eo.act ? {xr, yr, xr ^ yr} : 24'd0);
          chk($sformatf("c%0d line_start", c), vif.line_start, ls_e);
          chk($sformatf("c%0d frame_start", c), vif.frame_start, ls_e & eo.first);
          prev_de = eo.act;
          void'(hist.pop_front());
          hist.push_back(cur);
          cnt = en[c] ? (cnt + 1) % (HT * VT) : 0;
        end
        // Pixel source: answers each request exactly LAT cycles later, garbage otherwise.
        rq = '0;
        rq.act = vif.pix_req;
        rq.x = vif.pix_x;
        rq.y = vif.pix_y;
        src.push_back(rq);
        while (src.size() > LAT + 1) void'(src.pop_front());
        if (src.size() == LAT + 1 && src[0].act) begin
          vif.pix_r = src[0].x[7:0];
          vif.pix_g = src[0].y[7:0];
          vif.pix_b = src[0].x[7:0] ^ src[0].y[7:0];
        end else begin
          vif.pix_r = 8'hFF;
          vif.pix_g = 8'($urandom);
          vif.pix_b = 8'($urandom) | 8'h01;
        end
      end
    end
  end

  initial begin
    int k;
    int n_de;
    int n_ls;
    int n_fs;
    int n_hs;
    int n_vs;
    int hs_first;

    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2 en = 2'b11;
    #1 chk("req_before_E", {g_cfg[0].vif.pix_req, g_cfg[0].vif.pix_x, g_cfg[0].vif.pix_y}, {1'b1, 24'd0});
    k = 0;
    do begin @(posedge clk); #1 k++; end while (!g_cfg[0].vif.de_out && k < 20);
    chk("first_de_latency", k, 3);
    chk("first_frame_start", g_cfg[0].vif.frame_start, 1'b1);

    // Small raster: one full frame of aggregate counts
    k = 0;
    do begin @(negedge clk); k++; end while (!g_cfg[1].vif.frame_start && k < 100);
    chk("small_fs_seen", g_cfg[1].vif.frame_start, 1'b1);
    n_de = 0; n_ls = 0; n_fs = 0; n_hs = 0; n_vs = 0;
    for (int i = 0; i < 48; i++) begin
      n_de += int'(g_cfg[1].vif.de_out);
      n_ls += int'(g_cfg[1].vif.line_start);
      n_fs += int'(g_cfg[1].vif.frame_start);
      n_hs += int'(g_cfg[1].vif.hs_out);
      n_vs += int'(!g_cfg[1].vif.vs_out);
      @(negedge clk);
    end
    chk("small_frame_period", g_cfg[1].vif.frame_start, 1'b1);
    chk("small_de_count", n_de, 12);
    chk("small_ls_count", n_ls, 3);
    chk("small_fs_count", n_fs, 1);
    chk("small_hs_high", n_hs, 12);
    chk("small_vs_low", n_vs, 8);

    // Default raster: one full line
    k = 0;
    do begin @(negedge clk); k++; end while (!g_cfg[0].vif.line_start && k < 1000);
    chk("line_start_seen", g_cfg[0].vif.line_start, 1'b1);
    n_de = 0; n_ls = 0; n_hs = 0; hs_first = -1;
    for (int i = 0; i < 800; i++) begin
      n_de += int'(g_cfg[0].vif.de_out);
      n_ls += int'(g_cfg[0].vif.line_start);
      if (!g_cfg[0].vif.hs_out) begin
        n_hs++;
        if (hs_first < 0) hs_first = i;
      end
      @(negedge clk);
    end
    chk("line_period", g_cfg[0].vif.line_start, 1'b1);
    chk("line_de_count", n_de, 640);
    chk("line_ls_count", n_ls, 1);
    chk("line_hs_low", n_hs, 96);
    chk("line_hs_start", hs_first, 656);

    // Enable dropped mid-line for 5 cycles
    k = 0;
    do begin @(posedge clk); #1 k++; end
    while (!(g_cfg[0].vif.pix_req && g_cfg[0].vif.pix_x == 12'd300) && k < 2000);
    chk("x300_seen", g_cfg[0].vif.pix_x, 12'd300);
    #1 en[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2 en[0] = 1'b1;
    #1 chk("restart_xy", {g_cfg[0].vif.pix_req, g_cfg[0].vif.pix_x, g_cfg[0].vif.pix_y}, {1'b1, 24'd0});
    k = 0;
    do begin @(posedge clk); #1 k++; end while (!g_cfg[0].vif.frame_start && k < 20);
    chk("restart_fs_latency", k, 3);

    // Asynchronous reset in the middle of an active line
    k = 0;
    do begin @(posedge clk); #1 k++; end while (!(g_cfg[0].vif.de_out && g_cfg[0].vif.pix_x > 12'd20) && k < 2000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst0",
        {g_cfg[0].vif.de_out, g_cfg[0].vif.line_start, g_cfg[0].vif.frame_start, g_cfg[0].vif.hs_out,
         g_cfg[0].vif.vs_out, g_cfg[0].vif.r_out, g_cfg[0].vif.g_out, g_cfg[0].vif.b_out,
         g_cfg[0].vif.pix_req, g_cfg[0].vif.pix_x, g_cfg[0].vif.pix_y},
        {3'b000, 1'b1, 1'b1, 24'd0, 1'b0, 24'd0});
    chk("async_rst1",
        {g_cfg[1].vif.de_out, g_cfg[1].vif.hs_out, g_cfg[1].vif.vs_out, g_cfg[1].vif.pix_req},
        {1'b0, 1'b0, 1'b1, 1'b0});
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("post_rst_xy", {g_cfg[0].vif.pix_req, g_cfg[0].vif.pix_x, g_cfg[0].vif.pix_y}, {1'b1, 24'd0});

    // Random enable activity on both instances
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (en[0] ? ($urandom_range(0, 1999) == 0) : ($urandom_range(0, 3) == 0)) en[0] = ~en[0];
      if (en[1] ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 3) == 0)) en[1] = ~en[1];
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
